// File: rtl/mem_arbiter_pkg.sv
// Shared CPU constants: control-unit and memory-arbiter state encodings,
// requester identifiers and the default memory-access timeout.
// Contents: arb_state_t, cu_state_t, OWNER_IF/OWNER_D, ARB_TIMEOUT_DEFAULT.
package mem_arbiter_pkg;

    // Control-unit sequencing states.
    typedef enum logic [2:0] {
        CU_FETCH     = 3'd0,
        CU_DECODE    = 3'd1,
        CU_EXECUTE   = 3'd2,
        CU_MEMORY    = 3'd3,
        CU_WRITEBACK = 3'd4
    } cu_state_t;

    // Memory arbiter states; encoding 2'd3 is illegal and recovers to idle.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    // Requester identifiers, also the bit positions in the arbiter vectors.
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    // Maximum ACCESS cycles spent waiting for mem_ack.
    localparam int ARB_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// requester that was not granted last. Pure combinational, zero latency.
// Ports: req_i[1:0] (bit0 fetch, bit1 data), last_i (last owner), gnt_o one-hot.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    assign gnt_o[1] = req_i[1] & (~req_i[0] | (last_i == OWNER_IF));
    assign gnt_o[0] = req_i[0] & (~req_i[1] | (last_i == OWNER_D));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction-fetch and a data requester.
// Latency: request in IDLE -> mem_req next cycle -> done one cycle after ack
// (3 cycles minimum); a missing ack ends with bus_err after TIMEOUT cycles.
// Ports: if_* fetch side, d_* data side, mem_* memory side, bus_err pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    // Counter is at least 4 bits and always wide enough to hold TIMEOUT-1.
    localparam int CNT_W = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]        gnt;

    rr_arb2 u_rr_arb2 (
        .req_i  ({d_req, if_req}),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt != 2'b00) begin
                    state_d = ARB_ACCESS;
                    owner_d = gnt[1];
                    last_d  = gnt[1];
                    addr_d  = gnt[1] ? d_addr : if_addr;
                    // A fetch never writes, whatever d_we happens to be.
                    we_d    = gnt[1] & d_we;
                    wdata_d = gnt[1] ? d_wdata : '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ARB_ACCESS: begin
                if (mem_ack) begin
                    state_d = ARB_DONE;
                    if (owner_q == OWNER_D) d_rdata_d = mem_rdata;
                    else                    if_rdata_d = mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up: report an error and return zero data.
                    state_d = ARB_DONE;
                    err_d   = 1'b1;
                    if (owner_q == OWNER_D) d_rdata_d = '0;
                    else                    if_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWNER_IF;
            last_q     <= OWNER_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    logic in_access, in_done, busy;
    assign in_access = (state_q == ARB_ACCESS);
    assign in_done   = (state_q == ARB_DONE);
    assign busy      = in_access | in_done;

    assign mem_req   = in_access;
    assign mem_we    = in_access & we_q;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = in_access ? wdata_q : '0;

    assign if_gnt    = busy & (owner_q == OWNER_IF);
    assign d_gnt     = busy & (owner_q == OWNER_D);
    assign if_done   = in_done & (owner_q == OWNER_IF);
    assign d_done    = in_done & (owner_q == OWNER_D);
    assign bus_err   = in_done & err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions with hand-derived
// expectations fed through a scoreboard queue, plus tie, stray-ack and
// mid-access reset sequences.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       if_req, d_req, d_we, mem_ack;
    logic [7:0] if_addr, d_addr;
    logic [3:0] d_wdata, mem_rdata;
    logic       if_gnt, if_done, d_gnt, d_done, mem_req, mem_we, bus_err;
    logic [3:0] if_rdata, d_rdata, mem_wdata;
    logic [7:0] mem_addr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(4), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    typedef struct {
        logic       if_r, d_r, we;
        logic [7:0] ifa, da;
        logic [3:0] wd, rd;
        int         ack_wait;   // wait cycles before ack; >= 15 means never
        logic       e_d;        // 1: data port expected to own the access
        logic [7:0] e_addr;
        logic       e_we;
        logic [3:0] e_wdata;
        logic [3:0] e_rdata;    // owner's rdata at done
        logic [3:0] e_other;    // other requester's rdata, must be unchanged
        logic       e_err;
        int         e_acc;      // cycles with mem_req high
    } vec_t;

    vec_t vecs[9];
    vec_t exp_q[$];
    logic own_q[$];

    function automatic vec_t mk(logic if_r, logic d_r, logic we, logic [7:0] ifa,
                                logic [7:0] da, logic [3:0] wd, logic [3:0] rd, int ack_wait,
                                logic e_d, logic [7:0] e_addr, logic e_we, logic [3:0] e_wdata,
                                logic [3:0] e_rdata, logic [3:0] e_other, logic e_err, int e_acc);
        vec_t v;
        v.if_r = if_r; v.d_r = d_r; v.we = we; v.ifa = ifa; v.da = da; v.wd = wd;
        v.rd = rd; v.ack_wait = ack_wait; v.e_d = e_d; v.e_addr = e_addr; v.e_we = e_we;
        v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_other = e_other; v.e_err = e_err;
        v.e_acc = e_acc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({if_gnt, if_rdata, if_done, d_gnt, d_rdata, d_done,
                    mem_req, mem_we, mem_addr, mem_wdata, bus_err});
    endfunction

    // Drives one transaction at the current negedge, plays the memory, and
    // checks the completion against the queued expectation. Returns in IDLE.
    task automatic run_txn(input vec_t v, input string tag);
        vec_t e;
        int   cyc, acc, bad;
        bit   seen;
        exp_q.push_back(v);
        if_req = v.if_r; d_req = v.d_r; if_addr = v.ifa; d_addr = v.da;
        d_we = v.we; d_wdata = v.wd; mem_rdata = v.rd; mem_ack = 1'b0;
        cyc = 0; acc = 0; bad = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if_gnt && d_gnt) bad++;
            if (mem_req) begin
                e = exp_q[0];
                if (mem_addr !== e.e_addr || mem_we !== e.e_we || mem_wdata !== e.e_wdata ||
                    d_gnt !== e.e_d || if_gnt !== !e.e_d) bad++;
                mem_ack = (acc == v.ack_wait);
                acc++;
            end else begin
                mem_ack = 1'b0;
                if (mem_addr !== 8'h0 || mem_we !== 1'b0 || mem_wdata !== 4'h0) bad++;
            end
            if (if_done || d_done) begin
                seen = 1;
                e = exp_q.pop_front();
                check({tag, ".done"}, 32'({if_done, d_done}), e.e_d ? 32'h1 : 32'h2);
                check({tag, ".gnt"}, 32'({if_gnt, d_gnt}), e.e_d ? 32'h1 : 32'h2);
                check({tag, ".rdata"}, 32'(e.e_d ? d_rdata : if_rdata), 32'(e.e_rdata));
                check({tag, ".other_rdata"}, 32'(e.e_d ? if_rdata : d_rdata), 32'(e.e_other));
                check({tag, ".bus_err"}, 32'(bus_err), 32'(e.e_err));
                check({tag, ".mem_req_cycles"}, 32'(acc), 32'(e.e_acc));
                check({tag, ".latency"}, 32'(cyc), 32'(e.e_acc + 1));
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s.no_done: got none within %0d cycles, expected a done pulse", tag, cyc);
            exp_q.delete();
            if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        end
        check({tag, ".bus_signals"}, 32'(bad), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        int bad, ndone, cyc;

        //    if d  we ifa    da     wd    rd    ackw  e_d e_addr e_we e_wd  e_rd  e_oth err acc
        vecs[0] = mk(1, 0, 0, 8'h10, 8'h00, 4'h0, 4'hA, 0,  0, 8'h10, 0, 4'h0, 4'hA, 4'h0, 0, 1);
        vecs[1] = mk(0, 1, 1, 8'h00, 8'h3C, 4'h5, 4'h7, 3,  1, 8'h3C, 1, 4'h5, 4'h7, 4'hA, 0, 4);
        vecs[2] = mk(0, 1, 0, 8'h00, 8'h81, 4'h2, 4'hC, 1,  1, 8'h81, 0, 4'h2, 4'hC, 4'hA, 0, 2);
        vecs[3] = mk(1, 0, 1, 8'hFF, 8'h12, 4'h9, 4'h3, 2,  0, 8'hFF, 0, 4'h0, 4'h3, 4'hC, 0, 3);
        vecs[4] = mk(1, 1, 1, 8'h22, 8'h44, 4'h9, 4'h1, 0,  1, 8'h44, 1, 4'h9, 4'h1, 4'h3, 0, 1);
        vecs[5] = mk(1, 1, 0, 8'h5A, 8'h66, 4'h8, 4'h6, 0,  0, 8'h5A, 0, 4'h0, 4'h6, 4'h1, 0, 1);
        vecs[6] = mk(1, 0, 0, 8'h01, 8'h00, 4'h0, 4'hD, 99, 0, 8'h01, 0, 4'h0, 4'h0, 4'h1, 1, 15);
        vecs[7] = mk(0, 1, 0, 8'h00, 8'h02, 4'h0, 4'hE, 14, 1, 8'h02, 0, 4'h0, 4'hE, 4'h0, 0, 15);
        vecs[8] = mk(1, 0, 0, 8'h77, 8'h00, 4'h0, 4'hB, 0,  0, 8'h77, 0, 4'h0, 4'hB, 4'hE, 0, 1);

        // Reset with a request already pending: nothing may move.
        reset = 1'b0; if_req = 1'b1; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        if_addr = 8'h10; d_addr = 8'h0; d_wdata = 4'h0; mem_rdata = 4'h0;
        repeat (3) @(negedge clk);
        check("reset.outputs", all_outs(), 32'h0);

        // Release; first arbitration happens on the next edge.
        reset = 1'b1;
        for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Stray acks while idle must not complete anything or touch rdata.
        bad = 0;
        mem_ack = 1'b1; mem_rdata = 4'hF;
        repeat (3) begin
            @(negedge clk);
            if (if_done || d_done || mem_req || bus_err) bad++;
        end
        mem_ack = 1'b0;
        check("stray_ack.no_activity", 32'(bad), 32'h0);
        check("stray_ack.if_rdata", 32'(if_rdata), 32'hB);
        check("stray_ack.d_rdata", 32'(d_rdata), 32'hE);

        // Continuous tie after reset: D, IF, D, IF.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 8'h20; d_addr = 8'h40; mem_rdata = 4'h5;
        own_q.push_back(1'b1); own_q.push_back(1'b0);
        own_q.push_back(1'b1); own_q.push_back(1'b0);
        bad = 0; ndone = 0; cyc = 0;
        while (ndone < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_ack = mem_req;
            if (if_gnt && d_gnt) bad++;
            if (if_done || d_done) begin
                logic exp_own;
                exp_own = own_q.pop_front();
                check($sformatf("tie.order%0d", ndone), 32'({if_done, d_done}),
                      exp_own ? 32'h1 : 32'h2);
                ndone++;
            end
        end
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        check("tie.done_count", 32'(ndone), 32'h4);
        check("tie.both_gnt", 32'(bad), 32'h0);
        own_q.delete();
        repeat (2) @(negedge clk);

        // Reset during the second wait cycle of a data read.
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h99; mem_ack = 1'b0;
        @(negedge clk);
        check("rst_mid.first_wait", 32'({mem_req, d_gnt}), 32'h3);
        @(negedge clk);
        check("rst_mid.second_wait", 32'({mem_req, d_gnt}), 32'h3);
        reset = 1'b0; d_req = 1'b0; if_req = 1'b1;
        @(negedge clk);
        check("rst_mid.outputs", all_outs(), 32'h0);
        reset = 1'b1;
        run_txn(mk(1, 0, 0, 8'h33, 8'h00, 4'h0, 4'h4, 0, 0, 8'h33, 0, 4'h0, 4'h4, 4'h0, 0, 1),
                "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 4, memory data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, maximum ACCESS cycles waiting for mem_ack.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 if_req  input  1  instruction-fetch read request, held until if_done.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_gnt  output  1  fetch owns the memory port.
REQ-009 if_rdata  output  DATA_W  fetched data, valid when if_done=1.
REQ-010 if_done  output  1  one-cycle fetch completion pulse.
REQ-011 d_req  input  1  data-access request, held until d_done.
REQ-012 d_we  input  1  1=write, 0=read.
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wdata  input  DATA_W  write data.
REQ-015 d_gnt  output  1  data port owns the memory port.
REQ-016 d_rdata  output  DATA_W  read data, valid when d_done=1.
REQ-017 d_done  output  1  one-cycle data completion pulse.
REQ-018 mem_req, mem_we  output  1 each  memory strobe and write enable.
REQ-019 mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory address and write data.
REQ-020 mem_rdata  input  DATA_W; mem_ack  input  1  memory read data and completion.
REQ-021 bus_err  output  1  one-cycle pulse with *_done when the access timed out.

Function
REQ-022 The FSM SHALL have states IDLE, ACCESS, DONE; no other reachable state; illegal encodings go to IDLE.
REQ-023 IDLE: on any request, latch owner, address, we, wdata; clear timeout counter; go to ACCESS next cycle; otherwise stay.
REQ-024 Arbitration: single requester wins; both requesting -> the one NOT granted last wins (round-robin); the last-grant flag resets to "fetch", so data wins the first tie.
REQ-025 ACCESS: mem_req=1; mem_addr/mem_we/mem_wdata driven from latched values only; fetch forces mem_we=0.
REQ-026 ACCESS with mem_ack=1: capture mem_rdata into the owner's rdata register; go to DONE.
REQ-027 ACCESS without ack: increment 4-bit-or-wider counter; at count == TIMEOUT-1 without ack, set the error flag, load rdata with 0, go to DONE.
REQ-028 DONE: owner's *_done=1 for exactly one cycle; bus_err=1 in the same cycle if the timeout flag is set; then IDLE.
REQ-029 Grant: owner's *_gnt=1 in ACCESS and DONE; never both grants at once.
REQ-030 Latency: request seen in IDLE at cycle N -> mem_req at N+1 -> earliest done at N+2 (ack at N+1); minimum 3 cycles per access.
REQ-031 Requester dropping req mid-access SHALL be ignored; the access completes and done still pulses.
REQ-032 mem_ack outside ACCESS SHALL be ignored; rdata registers hold their value until the next completion for that owner.
REQ-033 mem_addr, mem_we, mem_wdata SHALL be 0 outside ACCESS.

Reset
REQ-034 reset=0 at a clock edge SHALL force IDLE, clear latched request, counter, error flag and last-grant (=fetch), and drive all outputs to 0, including mid-ACCESS (the access is abandoned and no done is produced).
REQ-035 The first arbitration SHALL occur on the first edge with reset=1.

Structure
REQ-036 FSM state encodings and the default TIMEOUT SHALL live in the shared CPU constants package alongside the control-unit state encodings.
REQ-037 The round-robin selector SHALL be one sub-module, rr_arb2 (2 requests, last-grant input, one-hot grant output); the rest is flat.

Verification
REQ-038 Lone fetch: if_req=1, if_addr=0x10, mem_rdata=0xA, ack on the first ACCESS cycle -> mem_req one cycle, if_done at cycle 2, if_rdata=0xA, bus_err=0.
REQ-039 Tie: if_req=d_req=1 continuously after reset -> grants alternate D, IF, D, IF; never both gnt high.
REQ-040 Data write: d_we=1, d_addr=0x3C, d_wdata=0x5, ack after 3 wait cycles -> mem_we=1, mem_addr=0x3C, mem_wdata=0x5 held 4 cycles, then d_done one cycle.
REQ-041 Timeout: d_req read, mem_ack never -> mem_req high exactly 15 cycles, d_done and bus_err pulse together, d_rdata=0, FSM returns to IDLE.
REQ-042 Reset mid-ACCESS: reset=0 during the second wait cycle -> next cycle all outputs 0, no done; after release, a pending if_req is served normally.
